// File: rtl/or_sweep_ctrl.sv
// Exhaustive self-test sweep for the or_gate datapath, checking every vector against a masked-OR golden model.
// Optional macro STOP_ON_FIRST_ERR_EN ends the sweep at the first mismatching vector.
module or_sweep_ctrl #(
    parameter int unsigned      WIDTH  = 10,
    parameter logic [WIDTH-1:0] MASK   = WIDTH'(10'h1FF),
    parameter int unsigned      SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] dut_in,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_count,
    output logic [WIDTH-1:0] first_err_vec,
    output logic             first_err_vld
);

    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [WIDTH-1:0] LAST_VEC   = '1;
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   err_q, err_d;
    logic [WIDTH-1:0] fev_q, fev_d;
    logic             fvld_q, fvld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             mismatch_c;

    // State and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fev_q   <= '0;
            fvld_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fvld_q  <= fvld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state, sweep bookkeeping and golden compare
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        fev_d      = fev_q;
        fvld_d     = fvld_q;
        mismatch_c = (|(vec_q & MASK)) != dut_out;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_WAIT;
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fev_d   = '0;
                    fvld_d  = 1'b0;
                end
            end
            ST_WAIT: begin
                if (cnt_q == SETTLE_END) begin
                    state_d = ST_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if (mismatch_c) begin
                    err_d = err_q + (WIDTH+1)'(1);
                    if (!fvld_q) begin
                        fev_d  = vec_q;
                        fvld_d = 1'b1;
                    end
                end
`ifdef STOP_ON_FIRST_ERR_EN
                if (mismatch_c || (vec_q == LAST_VEC)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                    vec_d   = vec_q + WIDTH'(1);
                end
`else
                if (vec_q == LAST_VEC) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                    vec_d   = vec_q + WIDTH'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_WAIT) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (err_d == '0);
    end

    assign dut_in        = vec_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_vec = fev_q;
    assign first_err_vld = fvld_q;

endmodule

// File: tb/tb_or_sweep_ctrl.sv
// Bench for or_sweep_ctrl: timeline model of the sweep for a SETTLE=1 instance plus directed checks,
// and a SETTLE=3 instance checked against hand-computed timing.
module tb_or_sweep_ctrl;
    localparam int unsigned W  = 10;
    localparam int unsigned N  = 1 << W;
    localparam int unsigned S1 = 1;
    localparam int unsigned S3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst1, start1, dut_out1, busy1, done1, pass1, fvld1;
    logic [W-1:0] dut_in1, fev1;
    logic [W:0]   err1;
    logic         rst3, start3, dut_out3, busy3, done3, pass3, fvld3;
    logic [W-1:0] dut_in3, fev3;
    logic [W:0]   err3;

    int mode;
    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    or_sweep_ctrl #(.WIDTH(W), .MASK(10'h1FF), .SETTLE(S1)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1), .dut_in(dut_in1), .dut_out(dut_out1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_vec(fev1), .first_err_vld(fvld1)
    );

    or_sweep_ctrl #(.WIDTH(W), .MASK(10'h1FF), .SETTLE(S3)) u_dut3 (
        .clk(clk), .rst(rst3), .start(start3), .dut_in(dut_in3), .dut_out(dut_out3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_err_vec(fev3), .first_err_vld(fvld3)
    );

    // Stand-in datapath: 0 = correct OR of bits 0..8, 1 = stuck-at-0, 2 = full 10-bit OR
    function automatic logic dut_fn(input int m, input logic [W-1:0] v);
        case (m)
            1:       return 1'b0;
            2:       return |v;
            default: return |v[8:0];
        endcase
    endfunction

    function automatic logic golden(input logic [W-1:0] v);
        return |(v & 10'h1FF);
    endfunction

    always_comb dut_out1 = dut_fn(mode, dut_in1);
    always_comb dut_out3 = |dut_in3[8:0];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Timeline model: m_k counts edges since the edge that accepted start
    bit m_run = 1'b0;
    int m_k   = 0;
    int m_pre [N+1];
    int m_first;
    int m_last;
    int m_end;

    task automatic m_arm();
        int c;
        c       = 0;
        m_first = -1;
        for (int v = 0; v < int'(N); v++) begin
            m_pre[v] = c;
            if (dut_fn(mode, W'(v)) != golden(W'(v))) begin
                c++;
                if (m_first < 0) m_first = v;
            end
        end
        m_pre[N] = c;
`ifdef STOP_ON_FIRST_ERR_EN
        m_last = (m_first >= 0) ? m_first : int'(N) - 1;
`else
        m_last = int'(N) - 1;
`endif
        m_end = (m_last + 1) * int'(S1 + 1);
    endtask

    always @(posedge clk) begin
        if (rst1) begin
            m_run = 1'b0;
            m_k   = 0;
        end else if (start1 && (!m_run || m_k >= m_end)) begin
            m_arm();
            m_run = 1'b1;
            m_k   = 0;
        end else if (m_run && m_k < m_end) begin
            m_k++;
        end
    end

    // Per-cycle compare of every output of the SETTLE=1 instance
    always @(negedge clk) begin
        logic [34:0] act, exp;
        int nchk, e_err, e_fev, e_din;
        bit e_busy, e_done, e_pass, e_vld;
        if (chk_en) begin
            if (!m_run) begin
                e_err = 0; e_fev = 0; e_din = 0;
                e_busy = 1'b0; e_done = 1'b0; e_pass = 1'b0; e_vld = 1'b0;
            end else begin
                nchk = m_k / int'(S1 + 1);
                if (nchk > m_last + 1) nchk = m_last + 1;
                e_err  = m_pre[nchk];
                e_vld  = (e_err > 0);
                e_fev  = e_vld ? m_first : 0;
                e_busy = (m_k < m_end);
                e_done = !e_busy;
                e_pass = e_done && (e_err == 0);
                e_din  = e_busy ? (m_k / int'(S1 + 1)) : m_last;
            end
            act = {busy1, done1, pass1, fvld1, fev1, err1, dut_in1};
            exp = {e_busy, e_done, e_pass, e_vld, W'(e_fev), (W+1)'(e_err), W'(e_din)};
            total++;
            if (act == exp) passed++;
            else $display("FAIL model_cycle k=%0d: got {busy,done,pass,vld,fev,err,din}=0x%0h expected 0x%0h",
                          m_k, act, exp);
        end
    end

    task automatic pulse1();
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
    endtask

    task automatic pulse3();
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
    endtask

    task automatic wait_done1(input int lim, output int n);
        n = 0;
        while (!done1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("done1_reached", 64'(done1), 64'd1);
    endtask

    task automatic wait_done3(input int lim, output int n);
        n = 0;
        while (!done3 && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("done3_reached", 64'(done3), 64'd1);
    endtask

    initial begin
        int n;
        rst1 = 1'b1; start1 = 1'b0; rst3 = 1'b1; start3 = 1'b0; mode = 0;
        repeat (2) @(negedge clk);
        rst1 = 1'b0; rst3 = 1'b0; chk_en = 1'b1;
        check("rst_busy", 64'(busy1), 64'd0);
        check("rst_done", 64'(done1), 64'd0);
        check("rst_pass", 64'(pass1), 64'd0);
        check("rst_din",  64'(dut_in1), 64'd0);
        check("rst_err",  64'(err1), 64'd0);
        check("rst_fvld", 64'(fvld1), 64'd0);
        check("rst_fev",  64'(fev1), 64'd0);

        // Correct datapath: full clean sweep
        mode = 0;
        pulse1();
        wait_done1(5000, n);
        check("ok_cycles", 64'(n), 64'd2048);
        check("ok_pass",   64'(pass1), 64'd1);
        check("ok_err",    64'(err1), 64'd0);
        check("ok_fvld",   64'(fvld1), 64'd0);
        check("ok_din",    64'(dut_in1), 64'h3FF);

        // Stuck-at-0 datapath, restarted from DONE
        mode = 1;
        pulse1();
        wait_done1(5000, n);
`ifdef STOP_ON_FIRST_ERR_EN
        check("sa0_cycles", 64'(n), 64'd4);
        check("sa0_err",    64'(err1), 64'd1);
        check("sa0_din",    64'(dut_in1), 64'h001);
`else
        check("sa0_cycles", 64'(n), 64'd2048);
        check("sa0_err",    64'(err1), 64'd1022);
`endif
        check("sa0_fev",  64'(fev1), 64'h001);
        check("sa0_fvld", 64'(fvld1), 64'd1);
        check("sa0_pass", 64'(pass1), 64'd0);

        // Datapath wrongly ORs the masked bit 9
        mode = 2;
        pulse1();
        wait_done1(5000, n);
        check("or10_err",  64'(err1), 64'd1);
        check("or10_fev",  64'(fev1), 64'h200);
        check("or10_pass", 64'(pass1), 64'd0);

        // Mid-sweep start is ignored; reset at vector 300 clears everything
        mode = 0;
        pulse1();
        n = 0;
        while (dut_in1 != 10'd300 && n < 2000) begin
            @(negedge clk);
            n++;
            start1 = (n == 100);
        end
        start1 = 1'b0;
        check("v300_cycles", 64'(n), 64'd600);
        rst1 = 1'b1;
        @(negedge clk) rst1 = 1'b0;
        check("midrst_busy", 64'(busy1), 64'd0);
        check("midrst_din",  64'(dut_in1), 64'd0);
        check("midrst_err",  64'(err1), 64'd0);

        // rst and start together: rst wins, start is not remembered
        pulse1();
        repeat (10) @(negedge clk);
        rst1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0; start1 = 1'b0;
        check("rstwin_busy", 64'(busy1), 64'd0);
        check("rstwin_done", 64'(done1), 64'd0);
        repeat (3) @(negedge clk);
        check("rstwin_idle", 64'(busy1), 64'd0);

        // SETTLE=3 instance: timing and restart from DONE
        pulse3();
        wait_done3(10000, n);
        check("s3_cycles", 64'(n), 64'd4096);
        check("s3_pass",   64'(pass3), 64'd1);
        check("s3_err",    64'(err3), 64'd0);
        check("s3_din",    64'(dut_in3), 64'h3FF);
        pulse3();
        check("s3_restart_done", 64'(done3), 64'd0);
        check("s3_restart_busy", 64'(busy3), 64'd1);
        check("s3_restart_din",  64'(dut_in3), 64'd0);
        wait_done3(10000, n);
        check("s3_cycles2", 64'(n), 64'd4096);
        check("s3_pass2",   64'(pass3), 64'd1);
        check("s3_fvld2",   64'(fvld3), 64'd0);
        check("s3_fev2",    64'(fev3), 64'd0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
